ldm_stm_sequencer: RTL and testbench

Multi-register transfer sequencer for the ARM7TDMI core. It executes one LDM or STM block transfer by walking a 16-bit register list from lowest to highest register. For each listed register it drives the register-file read or write port and issues one word access on a request/acknowledge memory port. It then optionally writes the updated base address back to the register file. It is the sole user of the register-file write port while `busy` is high.

---
 rtl/ldm_stm_sequencer.sv | 179 +++++++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: walks a 16-bit register list lowest-first,
// issues one word access per listed register, then optionally writes back the base.
module ldm_stm_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        is_load,
  input  logic [1:0]  mode,
  input  logic        writeback,
  input  logic [3:0]  base_reg,
  input  logic [31:0] base_addr,
  input  logic [15:0] reg_list,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  rf_read_num,
  input  logic [31:0] rf_read_data,
  output logic [3:0]  rf_write_reg,
  output logic [31:0] rf_write_data,
  output logic        rf_regwrite,
  output logic        busy,
  output logic        done,
  output logic [2:0]  dbg_state
);

  // Memory handshake: an access is in flight while mem_req=1 and completes in
  // the cycle mem_ack=1; address, direction and store data hold until then.
  typedef enum logic [2:0] {S_IDLE, S_XFER, S_DRAIN, S_WB, S_FIN} state_t;

  state_t      state_q, state_d;
  logic        is_load_q, is_load_d;
  logic        writeback_q, writeback_d;
  logic [3:0]  base_reg_q, base_reg_d;
  logic        base_in_list_q, base_in_list_d;
  logic [15:0] list_q, list_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] final_base_q, final_base_d;
  logic        pend_we_q, pend_we_d;
  logic [3:0]  pend_reg_q, pend_reg_d;
  logic [31:0] pend_data_q, pend_data_d;

  logic [4:0]  pop_cnt;
  logic [31:0] four_n;
  logic [31:0] start_addr;
  logic [3:0]  cur_reg;

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < 16; i++) pop_cnt = pop_cnt + 5'(reg_list[i]);
    four_n = {25'd0, pop_cnt, 2'b00};
    case (mode)
      2'b00:   start_addr = base_addr;
      2'b01:   start_addr = base_addr + 32'd4;
      2'b10:   start_addr = base_addr - four_n + 32'd4;
      default: start_addr = base_addr - four_n;
    endcase
  end

  // Scanning downward leaves the lowest set bit as the final assignment.
  always_comb begin
    cur_reg = '0;
    for (int i = 15; i >= 0; i--) begin
      if (list_q[i]) cur_reg = i[3:0];
    end
  end

  always_comb begin
    state_d        = state_q;
    is_load_d      = is_load_q;
    writeback_d    = writeback_q;
    base_reg_d     = base_reg_q;
    base_in_list_d = base_in_list_q;
    list_d         = list_q;
    addr_d         = addr_q;
    final_base_d   = final_base_q;
    pend_we_d      = 1'b0;
    pend_reg_d     = pend_reg_q;
    pend_data_d    = pend_data_q;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    rf_read_num    = '0;
    rf_write_reg   = '0;
    rf_write_data  = '0;
    rf_regwrite    = 1'b0;
    done           = 1'b0;

    // A load acked last cycle retires now; it only ever lands in XFER or DRAIN.
    if (pend_we_q) begin
      rf_regwrite   = 1'b1;
      rf_write_reg  = pend_reg_q;
      rf_write_data = pend_data_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_load_d      = is_load;
          writeback_d    = writeback;
          base_reg_d     = base_reg;
          base_in_list_d = reg_list[base_reg];
          list_d         = reg_list;
          addr_d         = start_addr;
          final_base_d   = mode[1] ? (base_addr - four_n) : (base_addr + four_n);
          state_d        = (reg_list == 16'd0) ? S_FIN : S_XFER;
        end
      end
      S_XFER: begin
        mem_req  = 1'b1;
        mem_we   = !is_load_q;
        mem_addr = addr_q;
        if (!is_load_q) begin
          rf_read_num = cur_reg;
          mem_wdata   = rf_read_data;
        end
        if (mem_ack) begin
          list_d = list_q & (list_q - 16'd1);
          addr_d = addr_q + 32'd4;
          if (is_load_q) begin
            pend_we_d   = 1'b1;
            pend_reg_d  = cur_reg;
            pend_data_d = mem_rdata;
          end
          if (list_d == 16'd0) state_d = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_WB;
      S_WB: begin
        if (writeback_q && !(is_load_q && base_in_list_q)) begin
          rf_regwrite   = 1'b1;
          rf_write_reg  = base_reg_q;
          rf_write_data = final_base_q;
        end
        state_d = S_FIN;
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      is_load_q      <= 1'b0;
      writeback_q    <= 1'b0;
      base_reg_q     <= '0;
      base_in_list_q <= 1'b0;
      list_q         <= '0;
      addr_q         <= '0;
      final_base_q   <= '0;
      pend_we_q      <= 1'b0;
      pend_reg_q     <= '0;
      pend_data_q    <= '0;
    end else begin
      state_q        <= state_d;
      is_load_q      <= is_load_d;
      writeback_q    <= writeback_d;
      base_reg_q     <= base_reg_d;
      base_in_list_q <= base_in_list_d;
      list_q         <= list_d;
      addr_q         <= addr_d;
      final_base_q   <= final_base_d;
      pend_we_q      <= pend_we_d;
      pend_reg_q     <= pend_reg_d;
      pend_data_q    <= pend_data_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer: drivers push expected memory accesses,
// register writes and done cycles into queues; a monitor pops and compares.
module tb_ldm_stm_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_load = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        writeback = 1'b0;
  logic [3:0]  base_reg = 4'd0;
  logic [31:0] base_addr = 32'd0;
  logic [15:0] reg_list = 16'd0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic [3:0]  rf_read_num;
  logic [31:0] rf_read_data;
  logic [3:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic        rf_regwrite, busy, done;
  logic [2:0]  dbg_state;

  ldm_stm_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .is_load(is_load), .mode(mode),
    .writeback(writeback), .base_reg(base_reg), .base_addr(base_addr),
    .reg_list(reg_list), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rf_read_num(rf_read_num), .rf_read_data(rf_read_data),
    .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
    .rf_regwrite(rf_regwrite), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Clock / reset and cycle counter
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard state
  logic [64:0] mem_q[$];   // {we, addr, wdata}
  logic [67:0] rf_q[$];    // {reg, data, cycle}
  logic [31:0] done_q[$];  // cycle of done
  int checks = 0;
  int failures = 0;
  int t0 = 0;
  int wait_cycles = 0;
  int wait_ctr = 0;

  // Register file model: combinational read port
  logic [31:0] rf_mem [16];
  assign rf_read_data = rf_mem[rf_read_num];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: wait_cycles low-ack cycles before each ack; load data = addr ^ A5A50000
  always @(negedge clock) begin
    if (mem_req && !reset) begin
      if (wait_ctr < wait_cycles) begin
        mem_ack = 1'b0;
        wait_ctr++;
      end else begin
        mem_ack = 1'b1;
        mem_rdata = mem_addr ^ 32'hA5A5_0000;
        wait_ctr = 0;
      end
    end else begin
      mem_ack = 1'b0;
      wait_ctr = 0;
    end
  end

  // Monitor: compares every presented access/write/done against queue heads
  always @(negedge clock) begin
    #1;
    if (!reset) begin
      if (mem_req) begin
        if (mem_q.size() == 0) check("mem_unexpected", {mem_we, mem_addr, mem_wdata}, 128'hDEAD);
        else begin
          check("mem_access", {mem_we, mem_addr, mem_wdata}, mem_q[0]);
          if (mem_ack) void'(mem_q.pop_front());
        end
      end
      if (rf_regwrite) begin
        if (rf_q.size() == 0) check("rf_unexpected", {rf_write_reg, rf_write_data}, 128'hDEAD);
        else check("rf_write", {rf_write_reg, rf_write_data, 32'(cyc)}, rf_q.pop_front());
      end
      if (done) begin
        if (done_q.size() == 0) check("done_unexpected", 32'(cyc), 128'hDEAD);
        else check("done_cycle", 32'(cyc), done_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic do_start(input logic ld, input logic [1:0] md, input logic wb,
                          input logic [3:0] br, input logic [31:0] ba, input logic [15:0] lst);
    @(posedge clock); #1;
    is_load = ld; mode = md; writeback = wb; base_reg = br; base_addr = ba; reg_list = lst;
    start = 1'b1;
    t0 = cyc;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic exp_mem(input logic we, input logic [31:0] a, input logic [31:0] d);
    mem_q.push_back({we, a, d});
  endtask

  task automatic exp_rf(input logic [3:0] r, input logic [31:0] d, input int c);
    rf_q.push_back({r, d, 32'(c)});
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!busy) break;
    end
    #2;
    check({name, "_idle"}, busy, 1'b0);
    repeat (2) @(posedge clock);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf_mem[i] = 32'h100 + i;
    rf_mem[0] = 32'hA; rf_mem[1] = 32'hB; rf_mem[4] = 32'hC;

    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", {mem_req, mem_we, mem_addr, mem_wdata, rf_read_num, rf_write_reg,
                            rf_write_data, rf_regwrite, busy, done}, 128'd0);
    reset = 1'b0;

    // STM IA
    do_start(1'b0, 2'b00, 1'b1, 4'd13, 32'h1000, 16'h0013);
    exp_mem(1'b1, 32'h1000, 32'hA); exp_mem(1'b1, 32'h1004, 32'hB); exp_mem(1'b1, 32'h1008, 32'hC);
    exp_rf(4'd13, 32'h100C, t0 + 5); done_q.push_back(32'(t0 + 6));
    wait_idle("stm_ia");

    // LDM DB
    do_start(1'b1, 2'b11, 1'b1, 4'd2, 32'h2000, 16'h8001);
    exp_mem(1'b0, 32'h1FF8, 32'h0); exp_mem(1'b0, 32'h1FFC, 32'h0);
    exp_rf(4'd0, 32'hA5A51FF8, t0 + 2); exp_rf(4'd15, 32'hA5A51FFC, t0 + 3);
    exp_rf(4'd2, 32'h1FF8, t0 + 4); done_q.push_back(32'(t0 + 5));
    wait_idle("ldm_db");

    // LDM IA with base in list: loaded value wins, no writeback
    do_start(1'b1, 2'b00, 1'b1, 4'd1, 32'h3000, 16'h0006);
    exp_mem(1'b0, 32'h3000, 32'h0); exp_mem(1'b0, 32'h3004, 32'h0);
    exp_rf(4'd1, 32'hA5A53000, t0 + 2); exp_rf(4'd2, 32'hA5A53004, t0 + 3);
    done_q.push_back(32'(t0 + 5));
    wait_idle("ldm_base");

    // STM IB with 3 wait cycles
    wait_cycles = 3;
    do_start(1'b0, 2'b01, 1'b0, 4'd0, 32'h0, 16'h0001);
    exp_mem(1'b1, 32'h4, 32'hA); done_q.push_back(32'(t0 + 7));
    wait_idle("wait_states");
    wait_cycles = 0;

    // Empty list
    do_start(1'b0, 2'b00, 1'b1, 4'd3, 32'h7000, 16'h0000);
    done_q.push_back(32'(t0 + 1));
    wait_idle("empty");

    // DB wrap: 0xFFFFFFFC then 0x0, final base 0xFFFFFFFC
    do_start(1'b0, 2'b11, 1'b1, 4'd5, 32'h4, 16'h0003);
    exp_mem(1'b1, 32'hFFFF_FFFC, 32'hA); exp_mem(1'b1, 32'h0, 32'hB);
    exp_rf(4'd5, 32'hFFFF_FFFC, t0 + 4); done_q.push_back(32'(t0 + 5));
    wait_idle("db_wrap");

    // DA wrap: base 0 -> 0xFFFFFFFC then 0x0, final base 0xFFFFFFF8
    do_start(1'b0, 2'b10, 1'b1, 4'd6, 32'h0, 16'h0003);
    exp_mem(1'b1, 32'hFFFF_FFFC, 32'hA); exp_mem(1'b1, 32'h0, 32'hB);
    exp_rf(4'd6, 32'hFFFF_FFF8, t0 + 4); done_q.push_back(32'(t0 + 5));
    wait_idle("da_wrap");

    // Reset during second XFER cycle
    do_start(1'b0, 2'b00, 1'b1, 4'd9, 32'h6000, 16'h0007);
    exp_mem(1'b1, 32'h6000, 32'hA);
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    check("midop_reset_outputs", {mem_req, mem_we, mem_addr, mem_wdata, rf_read_num, rf_write_reg,
                                  rf_write_data, rf_regwrite, busy, done}, 128'd0);
    check("midop_reset_state", dbg_state, 3'd0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (8) @(posedge clock);

    // Start while busy is ignored
    do_start(1'b0, 2'b00, 1'b0, 4'd0, 32'h5000, 16'h0003);
    exp_mem(1'b1, 32'h5000, 32'hA); exp_mem(1'b1, 32'h5004, 32'hB);
    done_q.push_back(32'(t0 + 5));
    is_load = 1'b1; reg_list = 16'hFFFF; base_addr = 32'h9000; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_idle("busy_start");

    check("mem_q_empty", 32'(mem_q.size()), 32'd0);
    check("rf_q_empty", 32'(rf_q.size()), 32'd0);
    check("done_q_empty", 32'(done_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
